// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, the shift FSM state type and a
// helper that tells whether an opcode is one of the three shifts.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLT  = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLTU = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b0111;
  localparam logic [3:0] OP_SRA  = 4'b1000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } shift_state_t;

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == OP_SRL) || (op == OP_SLL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_shift_step.sv
// One shift step: moves the value by 1 or 4 positions in the direction
// selected by the opcode, with zero fill (SRL/SLL) or sign fill (SRA).
module alu_shift_step
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic [3:0]       opcode,
  input  logic             step4,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = value;
    case (opcode)
      OP_SRL:  result = step4 ? (value >> 4) : (value >> 1);
      OP_SLL:  result = step4 ? (value << 4) : (value << 1);
      OP_SRA:  result = step4 ? WIDTH'($signed(value) >>> 4)
                              : WIDTH'($signed(value) >>> 1);
      default: result = value;
    endcase
  end

endmodule

// File: rtl/alu_shift_unit.sv
// Iterative shift stage behind the ALU slices (SRL/SLL/SRA, one step per cycle).
// Build option ALU_SHIFT_STEP4_EN: move 4 positions per cycle while count >= 4.
module alu_shift_unit
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [3:0]         operacion_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  output logic               ready_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [WIDTH-1:0]   resultado_o,
  output logic [1:0]         dbg_state_o
);

  // Handshake: a request transfers on a rising edge where start_i && ready_o;
  // inputs are sampled only then. done_o pulses for one cycle when resultado_o
  // holds the finished value, which stays put until the next transfer.

  shift_state_t       state;
  logic [SHAMT_W-1:0] count;
  logic [3:0]         op_q;
  logic [WIDTH-1:0]   result_q;
  logic [WIDTH-1:0]   step_result;
  logic               use4;
  logic [SHAMT_W-1:0] step_amt;
  logic               accept;
  logic [SHAMT_W-1:0] load_count;

`ifdef ALU_SHIFT_STEP4_EN
  assign use4 = (32'(count) >= 32'd4);
`else
  assign use4 = 1'b0;
`endif

  assign step_amt   = use4 ? SHAMT_W'(4) : SHAMT_W'(1);
  assign accept     = start_i && ready_o;
  // Non-shift opcodes complete immediately with operand A untouched.
  assign load_count = is_shift_op(operacion_i) ? shamt_i : '0;

  alu_shift_step #(.WIDTH(WIDTH)) u_step (
    .value  (result_q),
    .opcode (op_q),
    .step4  (use4),
    .result (step_result)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      count    <= '0;
      op_q     <= '0;
      result_q <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            result_q <= a_i;
            op_q     <= operacion_i;
            count    <= load_count;
            state    <= (load_count != '0) ? SHIFT : DONE;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          result_q <= step_result;
          count    <= count - step_amt;
          if (count == step_amt) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ready_o     = (state == IDLE) || (state == DONE);
  assign busy_o      = (state == SHIFT);
  assign done_o      = (state == DONE);
  assign resultado_o = result_q;
  assign dbg_state_o = state;

endmodule
